// File: rtl/sm_debug_ctrl_if.sv
// Host-side command channel and register-dump stream of the debug controller.
// The host is the master: it issues commands and accepts dump beats.
interface sm_debug_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, dump_ready,
    input  cmd_ready, dump_valid, dump_addr, dump_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, dump_ready,
    output cmd_ready, dump_valid, dump_addr, dump_data
  );
endinterface

// File: rtl/sm_debug_ctrl.sv
// Run/halt/step/dump controller for the schoolMIPS core. Gates the core
// clock enable, watches the PC on the debug read port for a breakpoint and
// streams a 32-entry register snapshot (PC + GPRs) while the core is frozen.
module sm_debug_ctrl #(
  parameter int CYCLE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  sm_debug_ctrl_if.slave     bus,
  input  logic               bp_en,
  input  logic [31:0]        bp_pc,
  output logic               cpu_en,
  output logic [4:0]         regAddr,
  input  logic [31:0]        regData,
  output logic               halted,
  output logic               bp_hit,
  output logic [CYCLE_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    ST_HALT,
    ST_RUN,
    ST_STEP,
    ST_DUMP_RD,
    ST_DUMP_OUT
  } state_t;

  localparam logic [1:0] OP_HALT = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_DUMP = 2'd3;

  state_t             r_state;
  logic               r_first;      // first cycle after entering RUN/STEP
  logic [15:0]        r_step_cnt;
  logic [4:0]         r_idx;        // dump index
  logic [4:0]         r_dump_addr;
  logic [31:0]        r_dump_data;
  logic               r_bp_hit;
  logic [CYCLE_W-1:0] r_cycle_cnt;

  logic w_exec;
  logic w_match;
  logic w_fire;
  logic w_halt_cmd;

  // Core is executing (RUN or STEP); regAddr points at the PC in these states.
  assign w_exec     = (r_state == ST_RUN) || (r_state == ST_STEP);
  // The first cycle is excluded so execution can resume from a PC sitting on the breakpoint.
  assign w_match    = w_exec && bp_en && (regData == bp_pc) && !r_first;
  assign w_fire     = bus.cmd_valid && bus.cmd_ready;
  assign w_halt_cmd = w_fire && (bus.cmd_op == OP_HALT);

  // Enable is combinational so the instruction at bp_pc never retires.
  assign cpu_en         = w_exec && !w_match;
  assign regAddr        = w_exec || (r_state == ST_HALT) ? 5'd0 : r_idx;
  assign halted         = (r_state == ST_HALT);
  assign bp_hit         = r_bp_hit;
  assign cycle_cnt      = r_cycle_cnt;
  assign bus.cmd_ready  = (r_state == ST_HALT) || w_exec;
  assign bus.dump_valid = (r_state == ST_DUMP_OUT);
  assign bus.dump_addr  = r_dump_addr;
  assign bus.dump_data  = r_dump_data;

  // Main sequencer: command decode, stepping, breakpoint stop and dump stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HALT;
      r_first     <= 1'b0;
      r_step_cnt  <= 16'd0;
      r_idx       <= 5'd0;
      r_dump_addr <= 5'd0;
      r_dump_data <= 32'd0;
      r_bp_hit    <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      case (r_state)
        ST_HALT: begin
          if (w_fire) begin
            case (bus.cmd_op)
              OP_RUN: begin
                r_state  <= ST_RUN;
                r_first  <= 1'b1;
                r_bp_hit <= 1'b0;
              end
              OP_STEP: begin
                r_state    <= ST_STEP;
                r_first    <= 1'b1;
                r_bp_hit   <= 1'b0;
                r_step_cnt <= (bus.cmd_arg == 16'd0) ? 16'd1 : bus.cmd_arg;
              end
              OP_DUMP: begin
                r_state <= ST_DUMP_RD;
                r_idx   <= 5'd0;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          r_first <= 1'b0;
          if (w_match) begin
            r_state  <= ST_HALT;
            r_bp_hit <= 1'b1;
          end else begin
            r_cycle_cnt <= r_cycle_cnt + CYCLE_W'(1);
            if (w_halt_cmd) r_state <= ST_HALT;
          end
        end
        ST_STEP: begin
          r_first <= 1'b0;
          // A breakpoint wins over the last step: no retire, no decrement.
          if (w_match) begin
            r_state  <= ST_HALT;
            r_bp_hit <= 1'b1;
          end else begin
            r_cycle_cnt <= r_cycle_cnt + CYCLE_W'(1);
            r_step_cnt  <= r_step_cnt - 16'd1;
            if ((r_step_cnt == 16'd1) || w_halt_cmd) r_state <= ST_HALT;
          end
        end
        ST_DUMP_RD: begin
          r_dump_data <= regData;
          r_dump_addr <= r_idx;
          r_state     <= ST_DUMP_OUT;
        end
        ST_DUMP_OUT: begin
          if (bus.dump_ready) begin
            if (r_idx == 5'd31) begin
              r_state <= ST_HALT;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_state <= ST_DUMP_RD;
            end
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// Bench for sm_debug_ctrl: a tiny straight-line core model (PC += 4 per
// enabled cycle, instruction at PC 0 is addiu $2,$0,7) answers the debug
// read port; dump beats are checked against a scoreboard queue.
module tb_sm_debug_ctrl;
  logic        clk;
  logic        rst;
  logic        bp_en;
  logic [31:0] bp_pc;
  logic        cpu_en;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        halted;
  logic        bp_hit;
  logic [31:0] cycle_cnt;

  sm_debug_ctrl_if bus_if ();

  sm_debug_ctrl #(.CYCLE_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .bp_en     (bp_en),
    .bp_pc     (bp_pc),
    .cpu_en    (cpu_en),
    .regAddr   (regAddr),
    .regData   (regData),
    .halted    (halted),
    .bp_hit    (bp_hit),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model
  logic [31:0] pc;
  logic [31:0] gpr [32];
  always @(posedge clk) begin
    if (rst) begin
      pc <= 32'd0;
      for (int i = 0; i < 32; i++) gpr[i] <= 32'(32'h1000 + i);
    end else if (cpu_en) begin
      pc <= pc + 32'd4;
      if (pc == 32'd0) gpr[2] <= 32'd7;
    end
  end
  assign regData = (regAddr == 5'd0) ? pc : gpr[regAddr];

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  logic [36:0] sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count enabled cycles
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_en === 1'b1) en_cnt++;
    end
  end

  // Dump monitor: pops one expectation per handshake, checks held beats stay stable
  initial begin
    logic        held_v;
    logic [36:0] held;
    logic [36:0] exp;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst || bus_if.dump_valid !== 1'b1) begin
        held_v = 1'b0;
      end else begin
        if (held_v) chk("dump_hold", {bus_if.dump_addr, bus_if.dump_data}, held);
        if (bus_if.dump_ready) begin
          if (sb.size() == 0) begin
            chk("dump_unexpected", {bus_if.dump_addr, bus_if.dump_data}, 64'h1_FFFF_FFFF_FFFF);
          end else begin
            exp = sb.pop_front();
            $display("dump beat addr=%0d data=%08h exp_addr=%0d exp_data=%08h",
                     bus_if.dump_addr, bus_if.dump_data, exp[36:32], exp[31:0]);
            chk("dump_beat", {bus_if.dump_addr, bus_if.dump_data}, exp);
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = {bus_if.dump_addr, bus_if.dump_data};
        end
      end
    end
  end

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input logic [31:0] pc_val, input logic [31:0] g2);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] d;
      if (i == 0)      d = pc_val;
      else if (i == 2) d = g2;
      else             d = 32'(32'h1000 + i);
      sb.push_back({5'(i), d});
    end
  endtask

  // Called just after a rising edge; returns 1ns after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg);
    int  waitc;
    bit  ok;
    waitc = 0;
    ok    = 1'b0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_arg   = arg;
    while (!ok && waitc < 200) begin
      @(negedge clk);
      if (bus_if.cmd_ready === 1'b1) ok = 1'b1;
      else waitc++;
      if (!ok) @(posedge clk);
    end
    if (!ok) chk("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
    $display("cmd op=%0d arg=%0d issued", op, arg);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    bit done;
    rst = 1'b1;
    bp_en = 1'b0;
    bp_pc = 32'd0;
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_op     = 2'd0;
    bus_if.cmd_arg    = 16'd0;
    bus_if.dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values, then 10 idle cycles
    @(negedge clk);
    chk("rst_outputs", {bus_if.dump_valid, bp_hit, regAddr, bus_if.dump_addr, bus_if.dump_data},
        64'd0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("idle", {halted, cpu_en, bus_if.cmd_ready, cycle_cnt}, {1'b1, 1'b0, 1'b1, 32'd0});
    end

    // STEP 5
    drive_slot();
    base = en_cnt;
    send_cmd(2'd2, 16'd5);
    bad = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (cpu_en !== (k <= 5)) bad++;
      if (halted !== (k >= 6)) bad++;
    end
    chk("step5_window", bad, 0);
    chk("step5_en_cycles", en_cnt - base, 5);
    chk("step5_state", {halted, cycle_cnt, pc}, {1'b1, 32'd5, 32'h14});

    // STEP 0 behaves as STEP 1
    drive_slot();
    send_cmd(2'd2, 16'd0);
    bad = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (cpu_en !== (k == 1)) bad++;
      if (halted !== (k >= 2)) bad++;
    end
    chk("step0_window", bad, 0);
    chk("step0_state", {halted, cycle_cnt, pc}, {1'b1, 32'd6, 32'h18});

    // Reset core and controller before the breakpoint run
    drive_slot();
    rst = 1'b1;
    drive_slot();
    rst = 1'b0;
    chk("rst_clears_cnt", {cycle_cnt, pc}, 64'd0);

    // RUN into breakpoint at 0x10
    bp_en = 1'b1;
    bp_pc = 32'h10;
    send_cmd(2'd1, 16'd0);
    done = 1'b0;
    bad  = 1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (pc == 32'h10 && halted === 1'b0) bad = (cpu_en === 1'b0) ? 0 : 2;
      if (halted === 1'b1) done = 1'b1;
    end
    chk("bp_halted", done, 1);
    chk("bp_cpu_en_drop", bad, 0);
    chk("bp_state", {bp_hit, cycle_cnt, pc}, {1'b1, 32'd4, 32'h10});

    // STEP 1 from the breakpoint PC executes it without re-hitting
    drive_slot();
    send_cmd(2'd2, 16'd1);
    repeat (3) @(negedge clk);
    chk("bp_resume", {halted, bp_hit, cycle_cnt, pc}, {1'b1, 1'b0, 32'd5, 32'h14});
    bp_en = 1'b0;

    // RUN, HALT accepted 20 edges later
    drive_slot();
    base = en_cnt;
    send_cmd(2'd1, 16'd0);
    repeat (19) @(posedge clk);
    #1;
    send_cmd(2'd0, 16'd0);
    @(negedge clk);
    chk("halt_cpu_en", {cpu_en, halted}, {1'b0, 1'b1});
    chk("halt_en_cycles", en_cnt - base, 20);
    chk("halt_cycle_cnt", cycle_cnt, 32'd25);
    repeat (5) @(negedge clk);
    chk("halt_pc_stable", pc, 32'h64);

    // DUMP with dump_ready held high: timing and contents
    bus_if.dump_ready = 1'b1;
    drive_slot();
    push_dump(32'h64, 32'd7);
    send_cmd(2'd3, 16'd0);
    bad = 0;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      if (bus_if.dump_valid !== (k >= 2 && k <= 64 && (k % 2) == 0)) bad++;
      if (k <= 63 && (k % 2) == 1 && regAddr !== 5'((k - 1) / 2)) bad++;
      if (bus_if.cmd_ready !== (k >= 65)) bad++;
      if (halted !== (k >= 65)) bad++;
    end
    chk("dump_timing", bad, 0);
    chk("dump_all_beats", sb.size(), 0);

    // DUMP with dump_ready toggling
    bus_if.dump_ready = 1'b0;
    drive_slot();
    push_dump(32'h64, 32'd7);
    send_cmd(2'd3, 16'd0);
    bad  = 0;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (halted === 1'b1) done = 1'b1;
      else if (bus_if.cmd_ready !== 1'b0) bad++;
      if (!done) begin
        @(posedge clk);
        #1;
        bus_if.dump_ready = ~bus_if.dump_ready;
      end
    end
    chk("dump_toggle_done", done, 1);
    chk("dump_toggle_cmd_ready", bad, 0);
    chk("dump_toggle_beats", sb.size(), 0);

    // Reset in the middle of a dump, at beat 10
    bus_if.dump_ready = 1'b1;
    drive_slot();
    push_dump(32'h64, 32'd7);
    send_cmd(2'd3, 16'd0);
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (bus_if.dump_valid === 1'b1 && bus_if.dump_addr == 5'd9) done = 1'b1;
    end
    chk("mid_dump_reach_beat9", done, 1);
    drive_slot();
    bus_if.dump_ready = 1'b0;
    drive_slot();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_dump_beat10", {bus_if.dump_valid, bus_if.dump_addr}, {1'b1, 5'd10});
    drive_slot();
    chk("mid_dump_rst", {bus_if.dump_valid, halted, bus_if.cmd_ready, bus_if.dump_addr},
        {1'b0, 1'b1, 1'b1, 5'd0});
    chk("mid_dump_remaining", sb.size(), 22);
    sb.delete();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus_if.dump_valid !== 1'b0) bad++;
    end
    chk("mid_dump_no_more_beats", bad, 0);

    // Fresh dump restarts at index 0 (core model was reset too)
    bus_if.dump_ready = 1'b1;
    drive_slot();
    push_dump(32'd0, 32'h1002);
    send_cmd(2'd3, 16'd0);
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (halted === 1'b1) done = 1'b1;
    end
    chk("redump_done", done, 1);
    chk("redump_beats", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
